generic_bus_ram_responder: RTL and testbench
============================================

Name: generic_bus_ram_responder

Overview:
Responder (slave) end of the generic_bus protocol. It is a word-addressed RAM with a programmable wait-state count that answers ren/wen requests from any generic_bus initiator, such as the memory controller's out_gen_bus_if or a cache. It is used as the on-chip scratch/boot RAM and as the memory endpoint in core-level benches. All outputs are registered.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 2.
BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.
LATENCY, 2, wait cycles between request acceptance and completion; 0..15.
OOR_DATA, 32'hBAD1_BAD1, read data returned for out-of-range addresses.

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
gen_bus_if.ren  in  1  read request
gen_bus_if.wen  in  1  write request
gen_bus_if.addr  in  32  byte address; bits [1:0] ignored
gen_bus_if.wdata  in  32  write data
gen_bus_if.byte_en  in  4  byte lane enables; bit i qualifies wdata[8i+7:8i]
gen_bus_if.rdata  out  32  read data; valid only while busy=0
gen_bus_if.busy  out  1  0 for exactly one cycle = transaction complete
(Signals are carried on generic_bus_if, modport generic_bus.)

Behaviour:
- Reset (async, nRST=0): state=IDLE, busy=1, rdata=0, wait counter=0. RAM contents are not reset. A pending write is discarded.
- Word index: idx=(addr-BASE_ADDR)>>2. The address is in range when idx<DEPTH_WORDS, computed in 32 bits with no wrap. Bits [1:0] are ignored.
- States:
  - IDLE: busy=1, rdata=0.
    - If ren|wen: latch addr, wdata, byte_en and kind (wen has priority when both are high). Load counter=LATENCY. Go to WAIT, or directly to DONE if LATENCY=0.
  - WAIT: busy=1.
    - counter decrements each cycle.
    - If ren=0 and wen=0 (initiator abort, e.g. an interrupt-dropped fetch): go to IDLE, no RAM access, no completion.
    - When counter=1 and the request is still present: go to DONE.
  - DONE: one cycle. busy=0.
    - Read: rdata=RAM[idx], or OOR_DATA if out of range.
    - Write: rdata=0. Bytes with byte_en[i]=1 are committed at the DONE-entry edge; other bytes are unchanged. Out-of-range writes are dropped silently but still complete.
    - Always go to IDLE next.
- Latency: request first sampled in IDLE at edge N -> busy=0 during cycle N+LATENCY+1. Back-to-back requests are spaced by at least LATENCY+2 cycles (IDLE is re-entered between transactions). A request held high through DONE is re-accepted as a new transaction in the following IDLE cycle.
- Latched values are used for the whole transaction. Changes to addr/wdata/byte_en during WAIT are ignored.
- A read following a write to the same word returns the new data (the write commits before the next IDLE).
- byte_en=0 on a write: completes normally, memory unchanged.
- Reset asserted in WAIT or DONE: immediate return to IDLE/busy=1. A write whose DONE edge has not occurred is not committed.
- The counter is 4 bits wide and never underflows (LATENCY=0 bypasses WAIT).

Test Plan:
1. LATENCY=2. Write addr 0x10, wdata 0xDEADBEEF, byte_en 4'hF at cycle N; then read 0x10 -> busy=0 at N+3 for the write; read busy=0 three cycles after acceptance with rdata=0xDEADBEEF.
2. Partial write: word 0x20 holds 0x11223344. Write wdata 0xAABBCCDD with byte_en 4'b0101 -> read returns 0x11BB33DD.
3. Abort: ren issued, then dropped on the cycle after acceptance -> busy stays 1, FSM in IDLE, no completion pulse. The next read completes normally.
4. Out of range, DEPTH_WORDS=1024: read 0x1000 -> rdata=0xBAD1BAD1, busy=0 once. Write to 0x1000 completes, and memory word 0 is unchanged.
5. LATENCY=0: held ren to three consecutive addresses -> busy=0 every 2nd cycle. rdata matches the preloaded words.
6. Assert nRST during WAIT of a write to 0x30 (previously 0x0) -> busy=1 and rdata=0 immediately. A read of 0x30 after reset returns 0x0.

Source files
------------

// File: rtl/generic_bus_ram_responder.sv
// Word-addressed generic_bus responder RAM: completes a request LATENCY+1 cycles after acceptance with a one-cycle busy=0 pulse.
// Requests are held by the initiator until busy drops; dropping ren/wen while waiting aborts without touching memory.
module generic_bus_ram_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] OOR_DATA    = 32'hBAD1_BAD1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ren,
  input  logic        i_wen,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_byte_en,
  output logic [31:0] o_rdata,
  output logic        o_busy
);

  localparam int unsigned AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH32 = 32'(DEPTH_WORDS);
  localparam logic [3:0]  LAT4    = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_is_wr;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_idle;
  logic        w_req;
  logic        w_accept;
  logic [31:0] w_tx_addr;
  logic [31:0] w_tx_wdata;
  logic [3:0]  w_tx_be;
  logic        w_tx_wr;
  logic [31:0] w_word;
  logic        w_in_range;
  logic [AW-1:0] w_idx;
  logic        w_to_done;
  logic        w_mem_we;

  assign w_idle   = (r_state == S_IDLE);
  assign w_req    = i_ren | i_wen;
  assign w_accept = w_idle & w_req;

  // With LATENCY=0 the DONE edge is the acceptance edge, so the live inputs are used there.
  assign w_tx_addr  = w_idle ? i_addr    : r_addr;
  assign w_tx_wdata = w_idle ? i_wdata   : r_wdata;
  assign w_tx_be    = w_idle ? i_byte_en : r_be;
  assign w_tx_wr    = w_idle ? i_wen     : r_is_wr;

  // Full 32-bit offset compare: addresses below BASE_ADDR wrap to huge indices and land out of range.
  assign w_word     = (w_tx_addr - BASE_ADDR) >> 2;
  assign w_in_range = (w_word < DEPTH32);
  assign w_idx      = w_word[AW-1:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_next = (LATENCY == 0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!w_req) begin
          w_next = S_IDLE;
        end else if (r_cnt == 4'd1) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_to_done = (w_next == S_DONE);
  // Gated by reset so a clock edge arriving while reset is held never commits a write.
  assign w_mem_we  = i_rst_n & w_to_done & w_tx_wr & w_in_range;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_is_wr <= 1'b0;
      o_busy  <= 1'b1;
      o_rdata <= 32'd0;
    end else begin
      r_state <= w_next;
      o_busy  <= ~w_to_done;
      if (w_to_done && !w_tx_wr) begin
        o_rdata <= w_in_range ? r_mem[w_idx] : OOR_DATA;
      end else begin
        o_rdata <= 32'd0;
      end
      if (w_accept) begin
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
        r_be    <= i_byte_en;
        r_is_wr <= i_wen;
        r_cnt   <= LAT4;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_tx_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_tx_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_generic_bus_ram_responder.sv
// Bench for generic_bus_ram_responder: a LATENCY=2 instance at base 0 and a LATENCY=0 instance at base 0x2000, checked against a word-array model.
module tb_generic_bus_ram_responder;

  localparam int          DEPTH2 = 1024;
  localparam int          DEPTH0 = 16;
  localparam logic [31:0] BASE0  = 32'h0000_2000;
  localparam logic [31:0] OOR    = 32'hBAD1_BAD1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ren, wen, ren0, wen0;
  logic [31:0] addr, wdata, addr0, wdata0;
  logic [3:0]  be, be0;
  logic [31:0] rdata, rdata0;
  logic        busy, busy0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem2 [DEPTH2];
  logic [31:0] mem0 [DEPTH0];

  generic_bus_ram_responder #(
    .DEPTH_WORDS(DEPTH2), .BASE_ADDR(32'h0), .LATENCY(2), .OOR_DATA(OOR)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ren(ren), .i_wen(wen), .i_addr(addr),
    .i_wdata(wdata), .i_byte_en(be), .o_rdata(rdata), .o_busy(busy)
  );

  generic_bus_ram_responder #(
    .DEPTH_WORDS(DEPTH0), .BASE_ADDR(BASE0), .LATENCY(0), .OOR_DATA(OOR)
  ) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ren(ren0), .i_wen(wen0), .i_addr(addr0),
    .i_wdata(wdata0), .i_byte_en(be0), .o_rdata(rdata0), .o_busy(busy0)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input bit sel, input logic [31:0] a);
    longint la, base, dep;
    la   = {32'd0, a};
    base = sel ? {32'd0, BASE0} : 64'd0;
    dep  = sel ? DEPTH0 : DEPTH2;
    return (la >= base) && (la < base + dep * 4);
  endfunction

  function automatic int widx(input bit sel, input logic [31:0] a);
    longint la, base;
    la   = {32'd0, a};
    base = sel ? {32'd0, BASE0} : 64'd0;
    return int'((la - base) / 4);
  endfunction

  function automatic logic [31:0] model_rd(input bit sel, input logic [31:0] a);
    if (!in_rng(sel, a)) return OOR;
    return sel ? mem0[widx(sel, a)] : mem2[widx(sel, a)];
  endfunction

  task automatic drive(input bit sel, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    if (sel) begin
      ren0 = r; wen0 = w; addr0 = a; wdata0 = d; be0 = b;
    end else begin
      ren = r; wen = w; addr = a; wdata = d; be = b;
    end
  endtask

  // One complete transaction; checks completion latency, data and the single-cycle busy pulse.
  task automatic txn(input bit sel, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic [31:0] rd);
    int k;
    logic [31:0] exp, mask;
    exp = wr ? 32'd0 : model_rd(sel, a);
    rd  = 32'hX;
    @(posedge clk); #1;
    drive(sel, !wr, wr, a, d, b);
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if ((sel ? busy0 : busy) == 1'b0) break;
      k++;
    end
    chk(sel ? "lat0_cycles" : "lat2_cycles", 32'(k), sel ? 32'd1 : 32'd3);
    if (k < 20) begin
      rd = sel ? rdata0 : rdata;
      chk(wr ? "wr_rdata" : "rd_rdata", rd, exp);
    end
    drive(sel, 1'b0, 1'b0, a, d, b);
    if (wr && in_rng(sel, a)) begin
      mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
      if (sel) mem0[widx(sel, a)] = (mem0[widx(sel, a)] & ~mask) | (d & mask);
      else     mem2[widx(sel, a)] = (mem2[widx(sel, a)] & ~mask) | (d & mask);
    end
    @(negedge clk);
    chk("busy_after_done", 32'(sel ? busy0 : busy), 32'd1);
    chk("rdata_after_done", sel ? rdata0 : rdata, 32'd0);
  endtask

  // Read request dropped on the cycle after acceptance; no completion may follow.
  task automatic abort_rd(input logic [31:0] a);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, a, 32'd0, 4'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, a, 32'd0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] rd, a;
    int r, k;

    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_busy0", 32'(busy0), 32'd1);
    chk("reset_rdata0", rdata0, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) txn(1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, rd);

    txn(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd);
    txn(1'b0, 1'b0, 32'h10, 32'd0, 4'h0, rd);
    chk("read_after_write", rd, 32'hDEAD_BEEF);

    txn(1'b0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, rd);
    txn(1'b0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, rd);
    txn(1'b0, 1'b0, 32'h22, 32'd0, 4'h0, rd);
    chk("partial_write", rd, 32'h11BB_33DD);

    abort_rd(32'h10);
    txn(1'b0, 1'b0, 32'h10, 32'd0, 4'h0, rd);
    chk("read_after_abort", rd, 32'hDEAD_BEEF);

    txn(1'b0, 1'b0, 32'h1000, 32'd0, 4'h0, rd);
    chk("oor_read", rd, 32'hBAD1_BAD1);
    txn(1'b0, 1'b1, 32'h1000, 32'h5555_AAAA, 4'hF, rd);
    txn(1'b0, 1'b0, 32'h0, 32'd0, 4'h0, rd);
    txn(1'b0, 1'b0, 32'hFFFF_FFFC, 32'd0, 4'h0, rd);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) a = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
      else                           a = 32'($urandom_range(0, 15)) << 2;
      a = a | 32'($urandom_range(0, 3));
      if (r == 0) abort_rd(a);
      else txn(1'b0, r[0], a, $urandom, 4'($urandom_range(0, 15)), rd);
    end

    for (int i = 0; i < 3; i++) txn(1'b1, 1'b1, BASE0 + 32'(i * 4), $urandom, 4'hF, rd);
    txn(1'b1, 1'b0, 32'h0, 32'd0, 4'h0, rd);
    chk("below_base_oor", rd, 32'hBAD1_BAD1);
    txn(1'b1, 1'b0, BASE0 + 32'h40, 32'd0, 4'h0, rd);

    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, BASE0, 32'd0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("held_idle_busy0", 32'(busy0), 32'd1);
      @(negedge clk);
      chk("held_done_busy0", 32'(busy0), 32'd0);
      chk("held_rdata0", rdata0, mem0[i]);
      addr0 = BASE0 + 32'((i + 1) * 4);
    end
    ren0 = 1'b0;

    txn(1'b0, 1'b1, 32'h30, 32'h0, 4'hF, rd);
    txn(1'b0, 1'b1, 32'h10, 32'hCAFE_F00D, 4'hF, rd);

    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 4'h0);
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (!busy) break;
      k++;
    end
    chk("pre_reset_done_rdata", rdata, 32'hCAFE_F00D);
    rst_n = 1'b0;
    #1;
    chk("reset_in_done_busy", 32'(busy), 32'd1);
    chk("reset_in_done_rdata", rdata, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h10, 32'd0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 32'h30, 32'hFFFF_FFFF, 4'hF);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_in_wait_busy", 32'(busy), 32'd1);
    chk("reset_in_wait_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h30, 32'd0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    txn(1'b0, 1'b0, 32'h30, 32'd0, 4'h0, rd);
    chk("write_dropped_by_reset", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
